// File: rtl/muldiv_issue_queue_pkg.sv
// Shared types for the mul/div issue path: ALU op encoding, ROB/PRF widths
// and the ROB age comparison used by both this queue and the unit itself.
package muldiv_issue_queue_pkg;

    localparam int unsigned ROB_WIDTH  = 3;
    localparam int unsigned PRF_WIDTH  = 6;
    localparam int unsigned XLEN_WIDTH = 32;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_SLT,
        ALU_SLTU,
        ALU_MUL,
        ALU_MULH,
        ALU_DIV,
        ALU_DIVU,
        ALU_REM,
        ALU_REMU
    } alu_op_type;

    typedef logic [ROB_WIDTH:0]   rob_id_t;
    typedef logic [PRF_WIDTH-1:0] prf_id_t;

    // 1 when tag a is younger than tag b; the MSB is the ROB wrap bit.
    function automatic logic rob_younger(input rob_id_t a, input rob_id_t b);
        return a[ROB_WIDTH] ^ b[ROB_WIDTH] ^ (a[ROB_WIDTH-1:0] > b[ROB_WIDTH-1:0]);
    endfunction

endpackage

// File: rtl/muldiv_issue_queue_rs_entry.sv
// One reservation-station slot: stores a dispatched micro-op, snoops the
// writeback broadcasts for its two sources and drops itself on issue or on
// a flush by an older branch.
module muldiv_rs_entry
    import muldiv_issue_queue_pkg::*;
#(
    parameter int unsigned WB_PORTS = 2
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               alloc,
    input  alu_op_type                         alloc_op,
    input  prf_id_t                            alloc_rs1_prf,
    input  prf_id_t                            alloc_rs2_prf,
    input  logic                               alloc_rs1_rdy,
    input  logic                               alloc_rs2_rdy,
    input  prf_id_t                            alloc_rd_prf,
    input  rob_id_t                            alloc_rob_id,
    input  logic                               release_en,
    input  logic [WB_PORTS-1:0]                wb_valid,
    input  logic [WB_PORTS-1:0][PRF_WIDTH-1:0] wb_prf,
    input  logic                               flush_valid,
    input  rob_id_t                            flush_robid,
    output logic                               valid,
    output logic                               ready,
    output alu_op_type                         op,
    output prf_id_t                            rs1_prf,
    output prf_id_t                            rs2_prf,
    output prf_id_t                            rd_prf,
    output rob_id_t                            rob_id
);

    logic rs1_rdy;
    logic rs2_rdy;
    logic wake1;
    logic wake2;
    logic alloc_wake1;
    logic alloc_wake2;
    logic squash;

    // Match the stored and the incoming source tags against every broadcast.
    always_comb begin
        wake1       = 1'b0;
        wake2       = 1'b0;
        alloc_wake1 = 1'b0;
        alloc_wake2 = 1'b0;
        for (int unsigned p = 0; p < WB_PORTS; p++) begin
            if (wb_valid[p]) begin
                if (wb_prf[p] == rs1_prf)       wake1       = 1'b1;
                if (wb_prf[p] == rs2_prf)       wake2       = 1'b1;
                if (wb_prf[p] == alloc_rs1_prf) alloc_wake1 = 1'b1;
                if (wb_prf[p] == alloc_rs2_prf) alloc_wake2 = 1'b1;
            end
        end
        squash = flush_valid & rob_younger(rob_id, flush_robid);
    end

    // Slot state: allocation never targets a valid slot, so it cannot
    // collide with release or squash of the same slot.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid   <= 1'b0;
            rs1_rdy <= 1'b0;
            rs2_rdy <= 1'b0;
            op      <= ALU_ADD;
            rs1_prf <= '0;
            rs2_prf <= '0;
            rd_prf  <= '0;
            rob_id  <= '0;
        end else if (alloc) begin
            valid   <= 1'b1;
            rs1_rdy <= alloc_rs1_rdy | alloc_wake1;
            rs2_rdy <= alloc_rs2_rdy | alloc_wake2;
            op      <= alloc_op;
            rs1_prf <= alloc_rs1_prf;
            rs2_prf <= alloc_rs2_prf;
            rd_prf  <= alloc_rd_prf;
            rob_id  <= alloc_rob_id;
        end else begin
            if (release_en || squash) valid <= 1'b0;
            if (wake1) rs1_rdy <= 1'b1;
            if (wake2) rs2_rdy <= 1'b1;
        end
    end

    assign ready = valid & rs1_rdy & rs2_rdy;

endmodule

// File: rtl/muldiv_issue_queue.sv
// Reservation station in front of the mul/div unit. Allocates dispatched
// ops into the lowest free slot, selects one ready slot while the unit is
// idle, reads the register file and registers a one-cycle start pulse.
// Build option: MDRS_AGE_SELECT_EN selects the oldest ready slot via an
// age matrix instead of the lowest-index ready slot.
module muldiv_issue_queue
    import muldiv_issue_queue_pkg::*;
#(
    parameter int unsigned RS_DEPTH = 4,
    parameter int unsigned WB_PORTS = 2
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               disp_valid,
    output logic                               disp_ready,
    input  alu_op_type                         disp_op,
    input  logic [PRF_WIDTH-1:0]               disp_rs1_prf,
    input  logic [PRF_WIDTH-1:0]               disp_rs2_prf,
    input  logic                               disp_rs1_rdy,
    input  logic                               disp_rs2_rdy,
    input  logic [PRF_WIDTH-1:0]               disp_rd_prf,
    input  logic [ROB_WIDTH:0]                 disp_rob_id,
    input  logic [WB_PORTS-1:0]                wb_valid,
    input  logic [WB_PORTS-1:0][PRF_WIDTH-1:0] wb_prf,
    input  logic                               flush_valid,
    input  logic [ROB_WIDTH:0]                 flush_robid,
    input  logic                               unit_busy,
    output logic [PRF_WIDTH-1:0]               prf_raddr1,
    output logic [PRF_WIDTH-1:0]               prf_raddr2,
    input  logic [XLEN_WIDTH-1:0]              prf_rdata1,
    input  logic [XLEN_WIDTH-1:0]              prf_rdata2,
    output logic                               iss_start,
    output alu_op_type                         iss_op,
    output logic [XLEN_WIDTH-1:0]              iss_left,
    output logic [XLEN_WIDTH-1:0]              iss_right,
    output logic [ROB_WIDTH:0]                 iss_rob_id,
    output logic [PRF_WIDTH-1:0]               iss_prf_id
);

    localparam int unsigned IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

    logic [RS_DEPTH-1:0] ent_valid;
    logic [RS_DEPTH-1:0] ent_ready;
    alu_op_type          ent_op  [RS_DEPTH];
    prf_id_t             ent_rs1 [RS_DEPTH];
    prf_id_t             ent_rs2 [RS_DEPTH];
    prf_id_t             ent_rd  [RS_DEPTH];
    rob_id_t             ent_rob [RS_DEPTH];

    logic             alloc_found;
    logic [IDX_W-1:0] alloc_idx;
    logic             disp_fire;
    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic             issue_fire;

    // Lowest-index free slot receives the next dispatch.
    always_comb begin
        alloc_found = 1'b0;
        alloc_idx   = '0;
        for (int unsigned i = 0; i < RS_DEPTH; i++) begin
            if (!ent_valid[i] && !alloc_found) begin
                alloc_found = 1'b1;
                alloc_idx   = IDX_W'(i);
            end
        end
    end

    // Occupancy is the pre-edge view, so a slot freed by issue this cycle
    // only becomes available to dispatch on the following cycle.
    assign disp_ready = ~(&ent_valid) & ~flush_valid;
    assign disp_fire  = disp_valid & disp_ready;

    for (genvar i = 0; i < RS_DEPTH; i++) begin : g_entry
        muldiv_rs_entry #(
            .WB_PORTS(WB_PORTS)
        ) u_entry (
            .clk          (clk),
            .reset_n      (reset_n),
            .alloc        (disp_fire && (alloc_idx == IDX_W'(i))),
            .alloc_op     (disp_op),
            .alloc_rs1_prf(disp_rs1_prf),
            .alloc_rs2_prf(disp_rs2_prf),
            .alloc_rs1_rdy(disp_rs1_rdy),
            .alloc_rs2_rdy(disp_rs2_rdy),
            .alloc_rd_prf (disp_rd_prf),
            .alloc_rob_id (disp_rob_id),
            .release_en   (issue_fire && (sel_idx == IDX_W'(i))),
            .wb_valid     (wb_valid),
            .wb_prf       (wb_prf),
            .flush_valid  (flush_valid),
            .flush_robid  (flush_robid),
            .valid        (ent_valid[i]),
            .ready        (ent_ready[i]),
            .op           (ent_op[i]),
            .rs1_prf      (ent_rs1[i]),
            .rs2_prf      (ent_rs2[i]),
            .rd_prf       (ent_rd[i]),
            .rob_id       (ent_rob[i])
        );
    end

`ifdef MDRS_AGE_SELECT_EN
    // older[j][i] = 1 means slot j was dispatched before slot i.
    logic [RS_DEPTH-1:0] older [RS_DEPTH];

    // A new slot is younger than everything currently valid.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned j = 0; j < RS_DEPTH; j++) older[j] <= '0;
        end else if (disp_fire) begin
            for (int unsigned j = 0; j < RS_DEPTH; j++) begin
                older[alloc_idx][j] <= 1'b0;
                older[j][alloc_idx] <= ent_valid[j];
            end
        end
    end

    // Pick the ready slot that no other ready slot is older than.
    always_comb begin
        logic blocked;
        blocked   = 1'b0;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int unsigned i = 0; i < RS_DEPTH; i++) begin
            blocked = 1'b0;
            for (int unsigned j = 0; j < RS_DEPTH; j++) begin
                if (ent_ready[j] && older[j][i]) blocked = 1'b1;
            end
            if (ent_ready[i] && !blocked && !sel_found) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end
`else
    // Pick the lowest-index ready slot.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int unsigned i = 0; i < RS_DEPTH; i++) begin
            if (ent_ready[i] && !sel_found) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end
`endif

    // Gating on iss_start spaces starts two cycles apart, covering the
    // unit's busy-rise latency.
    assign issue_fire = sel_found & ~unit_busy & ~iss_start & ~flush_valid;
    assign prf_raddr1 = sel_found ? ent_rs1[sel_idx] : '0;
    assign prf_raddr2 = sel_found ? ent_rs2[sel_idx] : '0;

    // Issue register: data fields hold after the pulse, only iss_start drops.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            iss_start  <= 1'b0;
            iss_op     <= ALU_ADD;
            iss_left   <= '0;
            iss_right  <= '0;
            iss_rob_id <= '0;
            iss_prf_id <= '0;
        end else begin
            iss_start <= issue_fire;
            if (issue_fire) begin
                iss_op     <= ent_op[sel_idx];
                iss_left   <= prf_rdata1;
                iss_right  <= prf_rdata2;
                iss_rob_id <= ent_rob[sel_idx];
                iss_prf_id <= ent_rd[sel_idx];
            end
        end
    end

endmodule
